// File: rtl/decode_queue_if.sv
// Fetch-side push and issue-side pop bundle for the pre-decoding instruction queue.
interface decode_queue_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned ISSUE = 2
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_instr;
    logic [31:0]           in_pc;
    logic [ISSUE-1:0]      out_valid;
    logic [ISSUE-1:0]      out_ready;
    logic [32*ISSUE-1:0]   out_instr;
    logic [32*ISSUE-1:0]   out_pc;
    logic [22*ISSUE-1:0]   out_ctrl;
    logic [CW-1:0]         count;

    // Fetch/issue side: drives pushes, pop requests and flush.
    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_ctrl, count
    );

    // Queue side.
    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_ctrl, count
    );
endinterface

// File: rtl/decode_queue.sv
// Pre-decoding instruction queue: decodes MIPS instructions into a 22-bit
// control word at enqueue and presents up to ISSUE entries in program order.
module decode_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned ISSUE = 2
) (
    input logic           clk,
    input logic           rst,
    decode_queue_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic       alu_src;
        logic       imm_sign;
        logic       hilo_wen;
        logic       mem2reg;
        logic       mem_en;
        logic       mem_wen;
        logic       mem_sign;
        logic [1:0] mem_size;
        logic       reg_dst;
        logic       reg_wen;
        logic       branch;
        logic       jump;
        logic       jal;
        logic       jr;
        logic       bal;
        logic       cp0_rd;
        logic       cp0_wen;
        logic       invalid;
        logic       syscall;
        logic       brk;
        logic       eret;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [31:0] instr);
        ctrl_t c;
        c = '0;
        case (instr[31:26])
            6'h00: begin
                case (instr[5:0])
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h10, 6'h12, 6'h20, 6'h21, 6'h22, 6'h23,
                    6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: begin
                        c.reg_dst = 1'b1;
                        c.reg_wen = 1'b1;
                    end
                    6'h11, 6'h13: c.hilo_wen = 1'b1;
                    6'h18, 6'h19, 6'h1a, 6'h1b: c = '0;
                    6'h08: begin
                        c.jump = 1'b1;
                        c.jr   = 1'b1;
                    end
                    6'h09: begin
                        c.reg_dst = 1'b1;
                        c.reg_wen = 1'b1;
                        c.jal     = 1'b1;
                        c.jr      = 1'b1;
                    end
                    6'h0c:   c.syscall = 1'b1;
                    6'h0d:   c.brk     = 1'b1;
                    default: c.invalid = 1'b1;
                endcase
            end
            6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
                c.alu_src = 1'b1;
                c.reg_wen = 1'b1;
            end
            6'h08, 6'h09, 6'h0a, 6'h0b: begin
                c.alu_src  = 1'b1;
                c.imm_sign = 1'b1;
                c.reg_wen  = 1'b1;
            end
            6'h02: c.jump = 1'b1;
            6'h03: begin
                c.reg_dst = 1'b1;
                c.reg_wen = 1'b1;
                c.jal     = 1'b1;
            end
            6'h04, 6'h05, 6'h06, 6'h07: begin
                c.imm_sign = 1'b1;
                c.branch   = 1'b1;
            end
            6'h01: begin
                case (instr[20:16])
                    5'h00, 5'h01: begin
                        c.imm_sign = 1'b1;
                        c.branch   = 1'b1;
                    end
                    5'h10, 5'h11: begin
                        c.imm_sign = 1'b1;
                        c.branch   = 1'b1;
                        c.reg_dst  = 1'b1;
                        c.reg_wen  = 1'b1;
                        c.bal      = 1'b1;
                    end
                    default: c.invalid = 1'b1;
                endcase
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                c.alu_src  = 1'b1;
                c.imm_sign = 1'b1;
                c.mem2reg  = 1'b1;
                c.mem_en   = 1'b1;
                c.mem_sign = (instr[31:26] == 6'h20) || (instr[31:26] == 6'h21);
                case (instr[31:26])
                    6'h21, 6'h25: c.mem_size = 2'b01;
                    6'h23:        c.mem_size = 2'b10;
                    default:      c.mem_size = 2'b00;
                endcase
            end
            6'h28, 6'h29, 6'h2b: begin
                c.alu_src  = 1'b1;
                c.imm_sign = 1'b1;
                c.mem_en   = 1'b1;
                c.mem_wen  = 1'b1;
                case (instr[31:26])
                    6'h29:   c.mem_size = 2'b01;
                    6'h2b:   c.mem_size = 2'b10;
                    default: c.mem_size = 2'b00;
                endcase
            end
            6'h10: begin
                if (instr == 32'h4200_0018) begin
                    c.cp0_rd = 1'b1;
                    c.eret   = 1'b1;
                end else begin
                    case (instr[25:21])
                        5'b00100: c.cp0_wen = 1'b1;
                        5'b00000: begin
                            c.reg_wen = 1'b1;
                            c.cp0_rd  = 1'b1;
                        end
                        default: c.invalid = 1'b1;
                    endcase
                end
            end
            default: c.invalid = 1'b1;
        endcase
        return c;
    endfunction

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];
    ctrl_t         ctrl_mem  [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic [1:0]    pop_n;
    logic [1:0]    rdy;
    logic [1:0]    vld;

    assign bus.in_ready = (count < CW'(DEPTH));
    assign bus.count    = count;

    // Push/pop qualification; slot 1 only pops alongside slot 0.
    always_comb begin
        rdy = '0;
        vld = '0;
        for (int unsigned k = 0; k < ISSUE; k++) begin
            rdy[k] = bus.out_ready[k];
            vld[k] = (count > CW'(k));
        end
        push  = bus.in_valid && bus.in_ready;
        pop_n = 2'(rdy[0] && vld[0]) + 2'(rdy[1] && vld[1] && rdy[0]);
    end

    // Pointer and occupancy update; flush wins over push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            count  <= '0;
            rd_ptr <= wr_ptr;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            rd_ptr <= rd_ptr + PW'(pop_n);
            count  <= count + CW'(push) - CW'(pop_n);
        end
    end

    // Entry storage written with the decoded control word at enqueue.
    always_ff @(posedge clk) begin
        if (push && !bus.flush) begin
            instr_mem[wr_ptr] <= bus.in_instr;
            pc_mem[wr_ptr]    <= bus.in_pc;
            ctrl_mem[wr_ptr]  <= decode(bus.in_instr);
        end
    end

    // Issue slots: k-th oldest entry, zeroed when the slot is empty.
    always_comb begin
        logic [PW-1:0] idx;
        bus.out_valid = '0;
        bus.out_instr = '0;
        bus.out_pc    = '0;
        bus.out_ctrl  = '0;
        idx           = '0;
        for (int unsigned k = 0; k < ISSUE; k++) begin
            idx = rd_ptr + PW'(k);
            if (count > CW'(k)) begin
                bus.out_valid[k]        = 1'b1;
                bus.out_instr[32*k +: 32] = instr_mem[idx];
                bus.out_pc[32*k +: 32]    = pc_mem[idx];
                bus.out_ctrl[22*k +: 22]  = ctrl_mem[idx];
            end
        end
    end
endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue (DEPTH=8, ISSUE=2).
module tb_decode_queue;
    logic clk = 1'b0;
    logic rst;

    decode_queue_if #(.DEPTH(8), .ISSUE(2)) bus();

    decode_queue #(.DEPTH(8), .ISSUE(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [21:0] ctrl;
    } entry_t;

    entry_t      sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] pc_ctr = 32'hBFC0_0000;
    logic [31:0] tab_instr [15];
    logic [21:0] tab_ctrl  [15];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive at negedge, compare at negedge+1, update scoreboard, advance.
    task automatic step(input logic v, input logic [31:0] instr, input logic [21:0] ctrl,
                        input logic [1:0] rdy, input logic fl);
        int     n;
        int     p;
        entry_t e;
        n = sb.size();
        bus.in_valid  = v;
        bus.in_instr  = v ? instr : 32'h0;
        bus.in_pc     = pc_ctr;
        bus.out_ready = rdy;
        bus.flush     = fl;
        #1;
        check("count", 64'(bus.count), 64'(n));
        check("in_ready", 64'(bus.in_ready), 64'(n < 8));
        check("out_valid", 64'(bus.out_valid), 64'({n > 1, n > 0}));
        for (int k = 0; k < 2; k++) begin
            if (k < n) begin
                check("slot_instr", 64'(bus.out_instr[32*k +: 32]), 64'(sb[k].instr));
                check("slot_pc", 64'(bus.out_pc[32*k +: 32]), 64'(sb[k].pc));
                check("slot_ctrl", 64'(bus.out_ctrl[22*k +: 22]), 64'(sb[k].ctrl));
            end else begin
                check("empty_slot", {bus.out_instr[32*k +: 32], bus.out_pc[32*k +: 32]}, 64'h0);
                check("empty_ctrl", 64'(bus.out_ctrl[22*k +: 22]), 64'h0);
            end
        end
        p = int'(rdy[0] && n > 0) + int'(rdy[1] && n > 1 && rdy[0]);
        if (fl) begin
            sb.delete();
        end else begin
            repeat (p) void'(sb.pop_front());
            if (v && n < 8) begin
                e.instr = instr;
                e.pc    = pc_ctr;
                e.ctrl  = ctrl;
                sb.push_back(e);
            end
        end
        if (v) pc_ctr = pc_ctr + 32'd4;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic [1:0] rdy);
        step(1'b0, 32'h0, 22'h0, rdy, 1'b0);
    endtask

    task automatic push_tab(input int i, input logic [1:0] rdy);
        step(1'b1, tab_instr[i], tab_ctrl[i], rdy, 1'b0);
    endtask

    initial begin
        int i;
        tab_instr[0]  = 32'h0022_1821; tab_ctrl[0]  = 22'h001800; // ADDU
        tab_instr[1]  = 32'h0800_0010; tab_ctrl[1]  = 22'h000200; // J
        tab_instr[2]  = 32'h1022_0003; tab_ctrl[2]  = 22'h100400; // BEQ
        tab_instr[3]  = 32'hAC22_0008; tab_ctrl[3]  = 22'h334000; // SW
        tab_instr[4]  = 32'h4002_6000; tab_ctrl[4]  = 22'h000820; // MFC0
        tab_instr[5]  = 32'h0040_F809; tab_ctrl[5]  = 22'h001980; // JALR
        tab_instr[6]  = 32'h0431_0002; tab_ctrl[6]  = 22'h101C40; // BGEZAL
        tab_instr[7]  = 32'h8022_0000; tab_ctrl[7]  = 22'h368000; // LB
        tab_instr[8]  = 32'h3C01_BFC0; tab_ctrl[8]  = 22'h200800; // LUI
        tab_instr[9]  = 32'h0020_0011; tab_ctrl[9]  = 22'h080000; // MTHI
        tab_instr[10] = 32'h0022_0018; tab_ctrl[10] = 22'h000000; // MULT
        tab_instr[11] = 32'h4082_6000; tab_ctrl[11] = 22'h000010; // MTC0
        tab_instr[12] = 32'h0402_0000; tab_ctrl[12] = 22'h000008; // bad REGIMM
        tab_instr[13] = 32'h0000_0001; tab_ctrl[13] = 22'h000008; // bad funct
        tab_instr[14] = 32'h0000_000D; tab_ctrl[14] = 22'h000002; // BREAK

        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state, then the basic decode sequence.
        idle(2'b00);
        step(1'b1, 32'h2401_0005, 22'h300800, 2'b00, 1'b0);
        step(1'b1, 32'h8C22_0004, 22'h364000, 2'b00, 1'b0);
        step(1'b1, 32'h0000_000C, 22'h000004, 2'b00, 1'b0);
        step(1'b1, 32'hFC00_0000, 22'h000008, 2'b00, 1'b0);
        step(1'b1, 32'h4200_0018, 22'h000021, 2'b00, 1'b0);
        repeat (4) idle(2'b11);

        // Fill to full, refused push while popping, drain with wrap.
        for (i = 0; i < 8; i++) push_tab(i, 2'b00);
        push_tab(8, 2'b11);
        repeat (5) idle(2'b11);

        // Partial acceptance.
        for (i = 9; i < 12; i++) push_tab(i, 2'b00);
        idle(2'b10);
        idle(2'b01);
        idle(2'b00);

        // Flush together with a push and a two-entry pop.
        step(1'b1, tab_instr[12], tab_ctrl[12], 2'b11, 1'b1);
        idle(2'b00);
        push_tab(13, 2'b00);
        push_tab(14, 2'b00);
        idle(2'b00);

        // Random traffic.
        for (i = 0; i < 80; i++) begin
            int t;
            t = $urandom_range(14);
            step(1'($urandom_range(1)), tab_instr[t], tab_ctrl[t],
                 2'($urandom_range(3)), ($urandom_range(15) == 0));
        end

        // Asynchronous reset mid-stream.
        push_tab(0, 2'b00);
        push_tab(1, 2'b00);
        bus.in_valid  = 1'b0;
        bus.out_ready = '0;
        bus.flush     = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'h0);
        check("rst_count", 64'(bus.count), 64'h0);
        check("rst_in_ready", 64'(bus.in_ready), 64'h1);
        check("rst_out_pc", 64'(bus.out_pc), 64'h0);
        #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        push_tab(2, 2'b00);
        push_tab(3, 2'b01);
        repeat (3) idle(2'b11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
